udp_tx_pkt_buf: RTL



---
 rtl/udp_tx_pkt_buf.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_pkt_buf.sv
// udp_tx_pkt_buf
// Packs a stream of 16-bit samples big-endian into a two-bank ping-pong
// buffer. When a bank fills, the read side announces the frame to the UDP
// transmitter with a start pulse and a byte count, then serves one payload
// byte per request strobe. The bank is handed back when the transmitter
// reports frame completion.
//
// Optional build macro: UDP_PKT_SEQ_HDR_EN
//   When defined, every frame is prefixed with a 4-byte big-endian sequence
//   number. It is 0 after reset and advances once per released frame.
//
// Ports
//   clk          system clock (GMII tx clock domain)
//   rst_n        asynchronous active-low reset
//   din          sample; din[15:8] goes on the wire first
//   din_valid    sample strobe, one sample per cycle
//   tx_req       byte request from the transmitter
//   tx_done      one-cycle pulse: transmitter finished the frame
//   tx_start_en  one-cycle start pulse to the transmitter
//   tx_byte_num  byte count of the pending frame
//   tx_data      byte answering the previous cycle's tx_req
//   overflow     one-cycle pulse per dropped sample
//   drop_cnt     dropped sample count, saturating at 16'hFFFF
module udp_tx_pkt_buf #(
  parameter int PKT_BYTES = 256,
  parameter int MEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [7:0]  tx_data,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int NW = PKT_BYTES / 2;
`ifdef UDP_PKT_SEQ_HDR_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam logic [15:0]       TOTAL  = 16'(PKT_BYTES + HDR);
  localparam logic [MEM_AW-1:0] LAST_W = MEM_AW'(NW - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  // Bank is the MSB of the RAM address.
  logic [15:0] mem_q [0:(2**(MEM_AW+1))-1];
  logic [15:0] rd_word_q;

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [MEM_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [1:0]        state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [MEM_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic              byte_sel_q, byte_sel_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic              tx_start_q, tx_start_d;
  logic [15:0]       byte_num_q, byte_num_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic wr_en, wr_last, drop, rel;
  logic in_hdr;
  logic [7:0] hdr_byte;

`ifdef UDP_PKT_SEQ_HDR_EN
  logic [31:0] seq_q, seq_d;

  always_comb begin
    in_hdr = (byte_cnt_q < 16'd4);
    case (byte_cnt_q[1:0])
      2'd0:    hdr_byte = seq_q[31:24];
      2'd1:    hdr_byte = seq_q[23:16];
      2'd2:    hdr_byte = seq_q[15:8];
      default: hdr_byte = seq_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= 32'd0;
    else        seq_q <= seq_d;
  end
`else
  assign in_hdr   = 1'b0;
  assign hdr_byte = 8'h00;
`endif

  // Write side: a sample aimed at a bank still owned by the reader is dropped.
  always_comb begin
    rel        = (state_q == S_REL);
    wr_en      = din_valid && !full_q[wr_bank_q];
    drop       = din_valid &&  full_q[wr_bank_q];
    wr_last    = wr_en && (wr_ptr_q == LAST_W);
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = drop;
    drop_cnt_d = drop_cnt_q;
    // Release and fill always target different banks, so both can apply.
    if (rel) full_d[rd_bank_q] = 1'b0;
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_ptr_d          = '0;
      wr_bank_d         = ~wr_bank_q;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Read FSM.
  always_comb begin
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;
    byte_sel_d = byte_sel_q;
    byte_cnt_d = byte_cnt_q;
    tx_start_d = 1'b0;
    byte_num_d = byte_num_q;
    tx_data_d  = tx_data_q;
`ifdef UDP_PKT_SEQ_HDR_EN
    seq_d      = seq_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Start pulse and byte count are registered on entry to START so
        // both are visible during the START cycle itself.
        if (full_q[rd_bank_q]) begin
          state_d    = S_START;
          tx_start_d = 1'b1;
          byte_num_d = TOTAL;
        end
      end
      S_START: begin
        rd_ptr_d   = '0;
        byte_sel_d = 1'b0;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_req) begin
          if (byte_cnt_q != TOTAL) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
            if (in_hdr) begin
              tx_data_d = hdr_byte;
            end else begin
              tx_data_d  = byte_sel_q ? rd_word_q[7:0] : rd_word_q[15:8];
              byte_sel_d = ~byte_sel_q;
              // Pointer parks on the last word instead of wrapping.
              if (byte_sel_q && rd_ptr_q != LAST_W) rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end else begin
            tx_data_d = 8'h00;
          end
        end
        if (tx_done) state_d = S_REL;
      end
      default: begin
        rd_bank_d = ~rd_bank_q;
`ifdef UDP_PKT_SEQ_HDR_EN
        seq_d     = seq_q + 32'd1;
`endif
        state_d   = S_IDLE;
      end
    endcase
  end

  // RAM: read address uses the next pointer so rd_word_q always holds the
  // word at the current rd_ptr_q, giving one-cycle req-to-data latency.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_ptr_q}] <= din;
    rd_word_q <= mem_q[{rd_bank_q, rd_ptr_d}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= S_IDLE;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
      byte_sel_q <= 1'b0;
      byte_cnt_q <= '0;
      tx_start_q <= 1'b0;
      byte_num_q <= '0;
      tx_data_q  <= '0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_sel_q <= byte_sel_d;
      byte_cnt_q <= byte_cnt_d;
      tx_start_q <= tx_start_d;
      byte_num_q <= byte_num_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start_en = tx_start_q;
  assign tx_byte_num = byte_num_q;
  assign tx_data     = tx_data_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
